// File: rtl/ex_issue_ctrl.sv
// Issue controller: registers decoded ops onto execute inputs, sequences multi-cycle ops, flushes on taken branch.
// Retire is same-cycle as mem_ready; back-to-back issue with zero bubble; optional perf counters under EX_ISSUE_PERF_EN.
module ex_issue_ctrl #(
   parameter int DATA_W      = 32,
   parameter int MUL_LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [DATA_W-1:0] id_data1,
   input  logic [DATA_W-1:0] id_data2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc,
   input  logic              id_multi,
   input  logic              id_is_branch,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_data1,
   output logic [DATA_W-1:0] ex_data2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc,
   output logic              ex_multi_start,
   input  logic              ex_compflg,
   input  logic              mem_ready,
   output logic              ex_retire,
   output logic              flush
`ifdef EX_ISSUE_PERF_EN
   ,
   output logic [31:0]       perf_retired,
   output logic [31:0]       perf_stall,
   output logic [15:0]       perf_flush
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC  = 2'd1,
      MULTI = 2'd2,
      FLUSH = 2'd3
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        r_cnt;
   logic              r_br_q;
   logic              r_ex_valid;
   logic              r_multi_start;
   logic [DATA_W-1:0] r_data1;
   logic [DATA_W-1:0] r_data2;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_pc;

   logic w_id_ready;
   logic w_accept;
   logic w_retire;
   logic w_kill;
   logic w_cnt_done;

   assign w_cnt_done = (r_cnt == 3'd0);
   // A retiring taken branch blocks issue so the wrong-path op is never captured.
   assign w_kill     = r_br_q & ex_compflg;
   assign w_retire   = r_ex_valid & mem_ready & ~rst_n &
                       ((r_state == EXEC) | ((r_state == MULTI) & w_cnt_done));
   assign w_accept   = id_valid & w_id_ready;

   always_comb begin
      w_id_ready  = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            w_id_ready = 1'b1;
            if (id_valid) begin
               w_state_nxt = id_multi ? MULTI : EXEC;
            end
         end
         EXEC, MULTI: begin
            if (r_state == EXEC) begin
               w_id_ready = mem_ready & ~w_kill;
            end else begin
               w_id_ready = w_cnt_done & mem_ready & ~w_kill;
            end
            if (w_retire) begin
               if (w_kill) begin
                  w_state_nxt = FLUSH;
               end else if (id_valid) begin
                  w_state_nxt = id_multi ? MULTI : EXEC;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         FLUSH: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      if (rst_n) begin
         w_id_ready = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= 3'd0;
         r_br_q        <= 1'b0;
         r_ex_valid    <= 1'b0;
         r_multi_start <= 1'b0;
         r_data1       <= '0;
         r_data2       <= '0;
         r_imm         <= '0;
         r_pc          <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_multi_start <= 1'b0;
         if (w_accept) begin
            r_ex_valid    <= 1'b1;
            r_data1       <= id_data1;
            r_data2       <= id_data2;
            r_imm         <= id_imm;
            r_pc          <= id_pc;
            r_br_q        <= id_is_branch;
            r_multi_start <= id_multi;
            r_cnt         <= id_multi ? CNT_INIT : 3'd0;
         end else begin
            if (w_retire) begin
               r_ex_valid <= 1'b0;
            end
            // Countdown runs regardless of mem_ready; only the final hold waits on it.
            if ((r_state == MULTI) && !w_cnt_done) begin
               r_cnt <= r_cnt - 3'd1;
            end
         end
      end
   end

   assign id_ready       = w_id_ready;
   assign ex_valid       = r_ex_valid;
   assign ex_data1       = r_data1;
   assign ex_data2       = r_data2;
   assign ex_imm         = r_imm;
   assign ex_pc          = r_pc;
   assign ex_multi_start = r_multi_start;
   assign ex_retire      = w_retire;
   assign flush          = (r_state == FLUSH);

`ifdef EX_ISSUE_PERF_EN
   logic [31:0] r_perf_retired;
   logic [31:0] r_perf_stall;
   logic [15:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_perf_retired <= '0;
         r_perf_stall   <= '0;
         r_perf_flush   <= '0;
      end else begin
         if (w_retire && (r_perf_retired != '1)) begin
            r_perf_retired <= r_perf_retired + 32'd1;
         end
         if (r_ex_valid && !w_retire && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if ((r_state == FLUSH) && (r_perf_flush != '1)) begin
            r_perf_flush <= r_perf_flush + 16'd1;
         end
      end
   end

   assign perf_retired = r_perf_retired;
   assign perf_stall   = r_perf_stall;
   assign perf_flush   = r_perf_flush;
`endif

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
Issue/sequencing controller in front of the execution stage.
- Accepts decoded instructions (operands, immediate, PC) from decode over a valid/ready handshake.
- Registers them onto the execution-stage inputs and holds them for multi-cycle operations or downstream back-pressure.
- Raises a one-cycle flush when a retiring branch resolves taken (compflg from the execution stage).

Parameters:
DATA_W, 32, width of data1/data2/immediate/PC.
MUL_LATENCY, 3, execute cycles a multi-cycle op occupies; legal range 1..8.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset; synchronous, active-high (asserted = 1).
id_valid  input  1  decode offers an instruction.
id_ready  output  1  controller accepts this cycle.
id_data1  input  DATA_W  operand 1.
id_data2  input  DATA_W  operand 2.
id_imm  input  DATA_W  immediate.
id_pc  input  DATA_W  program counter.
id_multi  input  1  instruction is multi-cycle.
id_is_branch  input  1  instruction is a conditional branch.
ex_valid  output  1  ex_* outputs hold a live instruction.
ex_data1, ex_data2, ex_imm, ex_pc  output  DATA_W each  registered operands to the execution stage.
ex_multi_start  output  1  one-cycle pulse on the first execute cycle of a multi-cycle op.
ex_compflg  input  1  branch-taken flag from the execution stage, same cycle.
mem_ready  input  1  downstream accepts the execute result this cycle.
ex_retire  output  1  pulse; the instruction leaves execute this cycle.
flush  output  1  one-cycle wrong-path kill to decode.

Behaviour:
States: IDLE, EXEC, MULTI, FLUSH. A countdown register cnt is 3 bits.

Reset:
- state=IDLE; ex_valid=0; ex_* operands=0; ex_multi_start=0; flush=0; cnt=0; branch latch br_q=0.
- id_ready=0 while rst_n=1.
- Reset mid-operation discards the held instruction with no ex_retire pulse.

id_ready (combinational):
- IDLE: 1.
- EXEC: mem_ready & !(br_q & ex_compflg).
- MULTI: (cnt==0) & mem_ready & !(br_q & ex_compflg).
- FLUSH: 0.

Accept (id_valid & id_ready at edge N):
- Capture operands and br_q <= id_is_branch.
- ex_valid=1 from N+1.
- If id_multi=0: go to EXEC.
- If id_multi=1: go to MULTI with cnt=MUL_LATENCY-1, and ex_multi_start=1 for cycle N+1 only.

Retire:
- Condition: ex_valid & mem_ready & (state==EXEC | (state==MULTI & cnt==0)).
- Effect: ex_retire=1 that cycle.
- A single-cycle op accepted at N retires earliest at cycle N+1.
- A multi-cycle op accepted at N retires earliest at cycle N+MUL_LATENCY.

MULTI:
- cnt decrements every cycle while >0, independent of mem_ready.
- At cnt==0, hold until mem_ready.

Back-pressure:
- While ex_valid and not retiring, ex_* outputs and br_q hold stable.

On retire:
- If br_q & ex_compflg: go to FLUSH.
- Else if id_valid (id_ready=1): capture the next instruction back-to-back (zero bubble).
- Else: ex_valid<=0 and go to IDLE.

FLUSH:
- Lasts exactly 1 cycle: flush=1, ex_valid=0, id_ready=0, id_valid ignored; next state IDLE.
- Decode drops its wrong-path instruction on flush.

Other rules:
- ex_compflg is sampled only in retire cycles when br_q=1; otherwise ignored.
- Multi-cycle branches: br_q is honoured at retire like any other op.
- MUL_LATENCY=1: MULTI behaves like EXEC but still pulses ex_multi_start.

Optional Feature:
Macro: EX_ISSUE_PERF_EN.
Defined:
- Adds outputs perf_retired (32), perf_stall (32), perf_flush (16).
- Counters saturate, no wrap, and clear on reset.
- perf_retired increments per ex_retire.
- perf_stall increments per cycle with ex_valid=1 and no retire.
- perf_flush increments per FLUSH cycle.

Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then single op: id_valid=1, data1=0x5, data2=0x7, pc=0x100, mem_ready=1. Expect ex_valid=1 and ex_data1=0x5 at N+1, ex_retire at N+1, back to IDLE.
- Back-to-back stream of 4 single ops with mem_ready=1. Expect 4 consecutive ex_retire pulses with no bubble and id_ready=1 throughout.
- Multi-cycle op with MUL_LATENCY=3. Expect ex_multi_start at N+1 only, id_ready=0 at N+1..N+2, ex_retire at N+3; with mem_ready=0 until N+6, retire at N+6 with ex_* stable throughout.
- Branch with ex_compflg=1 at retire and id_valid=1. Expect flush=1 the next cycle, ex_valid=0, the queued instruction not accepted, then IDLE. Same branch with ex_compflg=0: no flush, next instruction accepted back-to-back.
- Assert rst_n during MULTI (cnt=1). Expect ex_valid=0, no ex_retire, all ex_*=0, state IDLE next cycle.
- With EX_ISSUE_PERF_EN: 3 retires, 2 stall cycles, 1 flush. Expect perf_retired=3, perf_stall=2, perf_flush=1.
